// File: rtl/wptr_full_gen_if.sv
// Write-side bus of the async FIFO pointer block: producer request, synchronized
// read pointer in; RAM write controls, Gray pointer and status flags out.
// The walmost_full member exists only when WPTR_ALMOST_FULL_EN is defined.
interface wptr_full_gen_if #(
  parameter int unsigned ADDR_SIZE = 3
);
  logic                 winc;
  logic [ADDR_SIZE:0]   wq2_rptr;
  logic                 wen;
  logic [ADDR_SIZE-1:0] waddr;
  logic [ADDR_SIZE:0]   wptr;
  logic                 wfull;
  logic                 wovf;
`ifdef WPTR_ALMOST_FULL_EN
  logic                 walmost_full;

  modport master (
    output winc, wq2_rptr,
    input  wen, waddr, wptr, wfull, wovf, walmost_full
  );

  modport slave (
    input  winc, wq2_rptr,
    output wen, waddr, wptr, wfull, wovf, walmost_full
  );
`else
  modport master (
    output winc, wq2_rptr,
    input  wen, waddr, wptr, wfull, wovf
  );

  modport slave (
    input  winc, wq2_rptr,
    output wen, waddr, wptr, wfull, wovf
  );
`endif
endinterface

// File: rtl/wptr_full_gen.sv
// Write-domain pointer and full-flag generator for the async FIFO.
// Keeps a binary write pointer plus its registered Gray copy (sent to the
// read-domain synchronizer), drives RAM write controls, and derives a
// registered full flag and a sticky overflow flag from the synchronized
// read pointer. Optional almost-full flag: define WPTR_ALMOST_FULL_EN.
// ADDR_SIZE must be at least 2.
module wptr_full_gen #(
  parameter int unsigned ADDR_SIZE = 3
`ifdef WPTR_ALMOST_FULL_EN
  , parameter int unsigned AFULL_GAP = 2
`endif
) (
  input  logic           clk,
  input  logic           rst,
  wptr_full_gen_if.slave bus
);

  logic [ADDR_SIZE:0] wbin_q, wbin_d;
  logic [ADDR_SIZE:0] wptr_q, wgray_d;
  logic [ADDR_SIZE:0] rptr_full;
  logic               accept;
  logic               wfull_q, wfull_d;
  logic               wovf_q, wovf_d;

  // Next-state: advance on accepted write, compare Gray pointers for full.
  always_comb begin
    // Gated by rst so no write is ever signalled to the RAM during reset.
    accept  = bus.winc & ~wfull_q & rst;
    wbin_d  = wbin_q + {{ADDR_SIZE{1'b0}}, accept};
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    // Full when write pointer is one lap ahead: top two Gray bits inverted.
    rptr_full = bus.wq2_rptr ^ {2'b11, {(ADDR_SIZE - 1){1'b0}}};
    wfull_d   = (wgray_d == rptr_full);
    // Rejection uses the registered full flag, so a same-cycle read release
    // does not rescue a write attempted while full.
    wovf_d    = wovf_q | (bus.winc & wfull_q);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      wfull_q <= 1'b0;
      wovf_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wgray_d;
      wfull_q <= wfull_d;
      wovf_q  <= wovf_d;
    end
  end

  // Output drive.
  always_comb begin
    bus.wen   = accept;
    bus.waddr = wbin_q[ADDR_SIZE-1:0];
    bus.wptr  = wptr_q;
    bus.wfull = wfull_q;
    bus.wovf  = wovf_q;
  end

`ifdef WPTR_ALMOST_FULL_EN
  localparam int unsigned        Depth    = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] AfThresh = (ADDR_SIZE + 1)'(Depth - AFULL_GAP);

  logic [ADDR_SIZE:0] rq_bin;
  logic [ADDR_SIZE:0] level;
  logic               walmost_full_q, walmost_full_d;

  // Convert synchronized read pointer to binary and compute occupancy.
  always_comb begin
    rq_bin            = '0;
    rq_bin[ADDR_SIZE] = bus.wq2_rptr[ADDR_SIZE];
    for (int i = int'(ADDR_SIZE) - 1; i >= 0; i--) begin
      rq_bin[i] = rq_bin[i+1] ^ bus.wq2_rptr[i];
    end
    level          = wbin_d - rq_bin;
    walmost_full_d = (level >= AfThresh);
  end

  // Almost-full register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      walmost_full_q <= 1'b0;
    end else begin
      walmost_full_q <= walmost_full_d;
    end
  end

  // Almost-full output drive.
  always_comb begin
    bus.walmost_full = walmost_full_q;
  end
`endif

endmodule
